// File: rtl/mult32x32_pkg.sv
// -----------------------------------------------------------------------------
// mult32x32_pkg
//
// Shared types and constants for the 32x32 multiplier issue front-end.
//   OPERAND_W      - width of each unsigned multiplier operand
//   PRODUCT_W      - width of the full, untruncated product
//   issue_state_t  - issue FSM states (IDLE, START, WAIT)
//   operand_pair_t - packed {a, b} operand pair held in the operand FIFO
// -----------------------------------------------------------------------------
package mult32x32_pkg;

    localparam int unsigned OPERAND_W = 32;
    localparam int unsigned PRODUCT_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [OPERAND_W-1:0] a;
        logic [OPERAND_W-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/mult32x32_opfifo.sv
// -----------------------------------------------------------------------------
// mult32x32_opfifo
//
// Synchronous FIFO of operand pairs for the multiplier issue front-end.
// DEPTH must be a power of two and at least 2, so the read/write pointers wrap
// naturally at their own width.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-high reset; empties the FIFO
//   push       in   write push_data this cycle (ignored when full)
//   push_data  in   operand pair to store
//   pop        in   drop the head entry this cycle (ignored when empty)
//   pop_data   out  head entry, valid whenever empty is low
//   full       out  no free entries
//   empty      out  no stored entries
//   count      out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module mult32x32_opfifo
    import mult32x32_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  operand_pair_t push_data,
    input  logic          pop,
    output operand_pair_t pop_data,
    output logic          full,
    output logic          empty,
    output logic [CNT_W-1:0] count
);

    operand_pair_t      mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Guard against misuse so the occupancy can never over/underflow.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; stale entries are unreachable once empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mult32x32_issue.sv
// -----------------------------------------------------------------------------
// mult32x32_issue
//
// Streaming front-end for the 32x32 sequential multiplier. Operand pairs are
// accepted on a valid/ready interface into a small FIFO, launched one at a
// time into the multiplier with a single-cycle start pulse, and the 64-bit
// product is captured into an output register presented on a valid/ready
// result interface with backpressure. Results leave in acceptance order.
//
// Ports:
//   clk           in   clock
//   reset         in   asynchronous, active-high reset (shared with multiplier)
//   in_valid      in   operand pair valid
//   in_ready      out  FIFO not full; pair accepted on in_valid & in_ready
//   in_a, in_b    in   unsigned 32-bit operands
//   out_valid     out  out_product holds an unconsumed result
//   out_ready     in   consumer accepts; transfer on out_valid & out_ready
//   out_product   out  64-bit product A*B
//   mult_start    out  one-cycle start pulse to the multiplier FSM
//   mult_a/mult_b out  operands to the multiplier, stable from START to capture
//   mult_busy     in   multiplier busy
//   mult_product  in   multiplier product register
// -----------------------------------------------------------------------------
module mult32x32_issue
    import mult32x32_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPERAND_W-1:0] in_a,
    input  logic [OPERAND_W-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PRODUCT_W-1:0] out_product,
    output logic                 mult_start,
    output logic [OPERAND_W-1:0] mult_a,
    output logic [OPERAND_W-1:0] mult_b,
    input  logic                 mult_busy,
    input  logic [PRODUCT_W-1:0] mult_product
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    issue_state_t          state;
    operand_pair_t         op_q;
    logic                  mult_start_q;
    logic                  out_valid_q;
    logic [PRODUCT_W-1:0]  out_product_q;

    operand_pair_t         fifo_in;
    operand_pair_t         fifo_head;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    logic                  out_free;
    logic                  capture;

    // ------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------
    assign in_ready    = !fifo_full;
    assign fifo_push   = in_valid && in_ready;
    assign fifo_in.a   = in_a;
    assign fifo_in.b   = in_b;

    mult32x32_opfifo #(
        .DEPTH (DEPTH)
    ) u_opfifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Capture and pop decisions
    // ------------------------------------------------------------------
    // The output register can take a new product if it is empty or is being
    // drained this very cycle.
    assign out_free = !out_valid_q || out_ready;

    // The multiplier only updates its product while busy, so a finished
    // product stays valid for as long as the output is blocked.
    assign capture  = (state == WAIT) && !mult_busy && out_free;

    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            IDLE:    fifo_pop = !fifo_empty;
            WAIT:    fifo_pop = capture && !fifo_empty;
            default: fifo_pop = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Issue FSM with operand and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_q          <= '0;
            mult_start_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
        end else begin
            mult_start_q <= 1'b0;

            // Operands change only on a pop, which happens in IDLE or at the
            // capture cycle, so they are stable from START through capture.
            if (fifo_pop) begin
                op_q <= fifo_head;
            end

            // A capture in the same cycle as a consume keeps out_valid high
            // with the new product.
            if (capture) begin
                out_product_q <= mult_product;
                out_valid_q   <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state        <= START;
                        mult_start_q <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (capture) begin
                        if (!fifo_empty) begin
                            state        <= START;
                            mult_start_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Occupancy and the full/empty flags are derived from the same counter
    // and must always agree.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ((fifo_empty == (fifo_count == '0)) &&
                    (fifo_full == (fifo_count == CNT_W'(DEPTH))));
        end
    end

    assign mult_start  = mult_start_q;
    assign mult_a      = op_q.a;
    assign mult_b      = op_q.b;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;

endmodule

// File: tb/tb_mult32x32_issue.sv
module tb_mult32x32_issue;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_product;
    logic        mult_start;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic        mult_busy;
    logic [63:0] mult_product;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] sb [$];

    mult32x32_issue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_busy    (mult_busy),
        .mult_product (mult_product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: busy for the four cycles after the start cycle,
    // product register updated as busy falls.
    logic [1:0] mcnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mult_busy    <= 1'b0;
            mult_product <= '0;
            mcnt         <= '0;
        end else if (mult_start) begin
            mult_busy <= 1'b1;
            mcnt      <= 2'd3;
        end else if (mult_busy) begin
            if (mcnt == 2'd0) begin
                mult_busy    <= 1'b0;
                mult_product <= 64'(mult_a) * 64'(mult_b);
            end else begin
                mcnt <= mcnt - 2'd1;
            end
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    // Result monitor: every transfer pops the oldest expected product.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got 0x%016h, expected no result", out_product);
            end else begin
                check64("result", out_product, sb.pop_front());
            end
        end
    end

    // Operand stability from START through the capture cycle, and no start
    // pulse while the multiplier is busy.
    bit          stab_active = 1'b0;
    bit          seen_busy = 1'b0;
    logic [31:0] hold_a;
    logic [31:0] hold_b;
    always @(negedge clk) begin
        if (reset) begin
            stab_active = 1'b0;
            seen_busy   = 1'b0;
        end else begin
            if (stab_active) begin
                check64("operand_stable", {mult_a, mult_b}, {hold_a, hold_b});
                if (seen_busy && !mult_busy && (!out_valid || out_ready)) stab_active = 1'b0;
                if (mult_busy) seen_busy = 1'b1;
            end
            if (mult_start) begin
                check1("start_while_busy", mult_busy, 1'b0);
                stab_active = 1'b1;
                seen_busy   = 1'b0;
                hold_a      = mult_a;
                hold_b      = mult_b;
            end
        end
    end

    // Offers one pair and waits (bounded) for acceptance; called at posedge+1.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int waited = 0;
        bit done = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                done = 1'b1;
            end else if (waited >= 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0, expected 1");
                done = 1'b1;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    // Single pair into an idle block; cycle 0 is the acceptance cycle.
    task automatic single_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        out_ready = 1'b1;
        check1("idle_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        sb.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check1($sformatf("start_c%0d", c), mult_start, c == 2);
            check1($sformatf("valid_c%0d", c), out_valid, c == 8);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_in_ready"}, in_ready, 1'b1);
        check1({tag, "_out_valid"}, out_valid, 1'b0);
        check64({tag, "_out_product"}, out_product, 64'h0);
        check1({tag, "_mult_start"}, mult_start, 1'b0);
        check64({tag, "_mult_ab"}, {mult_a, mult_b}, 64'h0);
    endtask

    task automatic check_held(input string tag);
        @(negedge clk);
        check1({tag, "_in_ready_low"}, in_ready, 1'b0);
        check1({tag, "_valid_held"}, out_valid, 1'b1);
        check64({tag, "_product_held"}, out_product, 64'h3F);
    endtask

    logic [31:0] ra [6];
    logic [31:0] rb [6];
    logic [63:0] rp [6];
    int          tstamp [4];
    int          nres;
    int          ncol;
    bit          rdone;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        ra = '{32'h1, 32'h100, 32'hFFFFFFFF, 32'h0, 32'hA, 32'h10001};
        rb = '{32'h1, 32'h100, 32'h2, 32'hFFFFFFFF, 32'hB, 32'h10001};
        rp = '{64'h1, 64'h10000, 64'h1FFFFFFFE, 64'h0, 64'h6E, 64'h100020001};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single op with latency and start-pulse timing
        single_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        drain();

        // Back-to-back, results spaced 6 cycles
        out_ready = 1'b1;
        nres = 0;
        ncol = 0;
        fork
            begin
                send(32'd2, 32'd3, 64'd6);
                send(32'h10000, 32'h10000, 64'h100000000);
                send(32'h0, 32'h0, 64'h0);
                send(32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080);
            end
            begin
                while (nres < 4 && ncol < 100) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        tstamp[nres] = cyc;
                        nres++;
                    end
                    ncol++;
                end
            end
        join
        checks++;
        if (nres != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, expected 4", nres);
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (tstamp[i] - tstamp[i-1] != 6) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles, expected 6", i,
                             tstamp[i] - tstamp[i-1]);
                end
            end
        end
        drain();

        // Backpressure: FIFO fills, first result held, then all drain in order
        out_ready = 1'b0;
        fork
            begin
                send(32'd7, 32'd9, 64'h3F);
                send(32'hFFFF, 32'hFFFF, 64'hFFFE0001);
                send(32'h80000000, 32'h2, 64'h100000000);
                send(32'hDEADBEEF, 32'h1, 64'hDEADBEEF);
            end
            begin
                repeat (20) begin @(posedge clk); #1; end
                check_held("bp20");
                repeat (19) begin @(posedge clk); #1; end
                check_held("bp39");
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Directed vectors with random in_valid gaps and random out_ready
        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send(ra[i], rb[i], rp[i]);
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset mid-multiply with two pairs queued
        send(32'd3, 32'd5, 64'd15);
        send(32'd4, 32'd4, 64'd16);
        send(32'd6, 32'd7, 64'd42);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check1("post_reset_no_valid", out_valid, 1'b0);
            check1("post_reset_no_start", mult_start, 1'b0);
            @(posedge clk);
            #1;
        end
        single_op(32'h0000FFFF, 32'h00010000, 64'hFFFF0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult32x32_issue.md
# mult32x32_issue

Streaming front-end for the 32x32 sequential multiplier. Accepts operand pairs on a valid/ready interface and buffers them in a small FIFO. Launches each pair into the multiplier FSM/datapath with a one-cycle start pulse and holds the operands stable for the whole 4-cycle multiply. Captures the 64-bit product into an output register presented on a valid/ready result interface with backpressure.

## Interface
- DEPTH, 2: operand FIFO entries; power of two, >= 2.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO not full; pair accepted when in_valid & in_ready.
- in_a  in  32  operand A (unsigned).
- in_b  in  32  operand B (unsigned).
- out_valid  out  1  out_product holds an unconsumed result.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- out_product  out  64  product A*B.
- mult_start  out  1  start pulse to multiplier FSM.
- mult_a  out  32  operand A to multiplier datapath, stable from START through the capture cycle.
- mult_b  out  32  operand B, same rule.
- mult_busy  in  1  multiplier busy.
- mult_product  in  64  multiplier product register.

## Operation
- Operand FIFO: push on in_valid & in_ready. in_ready = !full, with no pass-through when full. Pop only by the control FSM. Pointers wrap modulo DEPTH. Occupancy counter width is $clog2(DEPTH+1).
- Operand register (op_a, op_b) drives mult_a/mult_b. It loads only on FIFO pop.
- FSM states:
  - IDLE: if FIFO non-empty, pop into the operand register and go to START.
  - START: mult_start=1 for exactly this cycle; go to WAIT.
  - WAIT: mult_busy is 1 for the four multiply cycles. Capture when mult_busy==0 and (!out_valid | out_ready).
    - Capture loads out_product<=mult_product and sets out_valid<=1.
    - Then, if the FIFO is non-empty, pop and go to START; else go to IDLE.
    - If busy==0 but the output is blocked, stay in WAIT. The product remains valid because the idle multiplier does not update it.
- out_valid clears on out_valid & out_ready with no simultaneous capture. A capture in the same cycle keeps it at 1 with new data.
- Results leave in acceptance order; exactly one result per accepted pair.
- Arithmetic is performed by the multiplier. This block adds no width changes: 32b x 32b unsigned gives 64b, with no truncation.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_product=0, mult_start=0, mult_a=0, mult_b=0.
  - FSM=IDLE, FIFO empty.
- Reset mid-operation discards all FIFO contents, any in-flight multiply and any held result. Reset is shared with the multiplier.
- Single pair into an empty, idle block, accepted at cycle 0:
  - pop at 1, mult_start at 2, mult_busy 3..6, capture at 7, out_valid=1 at cycle 8.
  - Latency is 8 cycles.
- Sustained throughput is one result per 6 cycles (START, 4 busy, capture) with out_ready held 1.
- mult_start is never asserted while mult_busy=1 or in WAIT.
- Simultaneous push and pop on a full FIFO is impossible, since in_ready=0 when full. Push and pop in the same cycle on a partly-full FIFO keeps the count unchanged.
- Backpressure: out_ready=0 with out_valid=1 stalls in WAIT after busy falls. The FIFO keeps filling until full, then in_ready drops.

## Structure
- Package mult32x32_pkg holds:
  - issue FSM enum {IDLE, START, WAIT};
  - OPERAND_W=32 and PRODUCT_W=64 constants;
  - a packed operand-pair struct {a, b}.
- Sub-module mult32x32_opfifo: parameterised DEPTH synchronous FIFO of the operand-pair struct, with push/pop/full/empty/count.
- The top contains the FSM, operand register and output register only.

## Test plan
- Single op: a=0xFFFFFFFF, b=0xFFFFFFFF accepted at cycle 0 -> out_valid at cycle 8, out_product=0xFFFFFFFE00000001, mult_start high only at cycle 2.
- Back-to-back: 4 pairs (2x3, 0x10000x0x10000, 0x0, 0x12345678x0x9ABCDEF0), out_ready=1 -> results 6, 0x100000000, 0, 0x0B00EA4E242D2080 in order, spaced 6 cycles.
- Backpressure: 4 pairs with out_ready=0 until cycle 40 -> in_ready drops once the FIFO is full, first result held unchanged, then all 4 drain in order with none lost or duplicated.
- Operand stability: mult_a/mult_b checked constant from START through the capture cycle while new pairs are pushed.
- Reset mid-multiply at cycle 4 of an operation with 2 pairs queued -> all outputs at reset values, no out_valid afterwards, and a new pair after reset completes correctly in 8 cycles.
- Random pairs, random in_valid/out_ready -> scoreboard against a*b, with order and count matching.
